// File: rtl/long_to_double_pkg.sv
// Shared binary64 constants, state encoding and packing helper for the
// integer/double converters.
package long_to_double_pkg;

  localparam int unsigned DBL_BIAS   = 1023;
  localparam int unsigned DBL_EXP_W  = 11;
  localparam int unsigned DBL_FRAC_W = 52;
  localparam int unsigned DBL_MANT_W = DBL_FRAC_W + 1;

  localparam logic [DBL_EXP_W-1:0] DBL_EXP_ONE  = DBL_EXP_W'(1);
  // Exponent of a 64-bit magnitude whose MSB sits at bit 63.
  localparam logic [DBL_EXP_W-1:0] L2D_EXP_INIT = DBL_EXP_W'(63 + DBL_BIAS);

  typedef enum logic [2:0] {
    GET_A,
    CONVERT_0,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } l2d_state_e;

  function automatic logic [63:0] dbl_pack(input logic                  s,
                                           input logic [DBL_EXP_W-1:0]  e,
                                           input logic [DBL_FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/long_to_double_double_round.sv
// Round-to-nearest-even of a normalised 64-bit magnitude down to a binary64
// fraction, with exponent bump on mantissa carry-out.
module double_round
  import long_to_double_pkg::*;
(
  input  logic [63:0]           m_i,
  input  logic [DBL_EXP_W-1:0]  e_i,
  output logic [DBL_FRAC_W-1:0] frac_o,
  output logic [DBL_EXP_W-1:0]  e_o
);

  logic              guard;
  logic              rnd;
  logic              sticky;
  logic              inc;
  logic [DBL_MANT_W:0] sum;

  always_comb begin
    guard  = m_i[10];
    rnd    = m_i[9];
    sticky = |m_i[8:0];
    inc    = guard && (rnd || sticky || m_i[11]);
    sum    = {1'b0, m_i[63:11]} + {{DBL_MANT_W{1'b0}}, inc};
    // Carry-out means the mantissa became 2^53; renormalise by one place.
    if (sum[DBL_MANT_W]) begin
      frac_o = sum[DBL_FRAC_W:1];
      e_o    = e_i + DBL_EXP_ONE;
    end else begin
      frac_o = sum[DBL_FRAC_W-1:0];
      e_o    = e_i;
    end
  end

endmodule

// File: rtl/long_to_double.sv
// Signed 64-bit integer to IEEE-754 binary64 converter with strobe/ack
// handshakes on both sides; normalises one bit per cycle.
module long_to_double
  import long_to_double_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  l2d_state_e state_q, state_d;
  logic       a_ack_q, a_ack_d;
  logic       z_stb_q, z_stb_d;

  logic [63:0]           a_q, a_d;
  logic                  s_q, s_d;
  logic [63:0]           m_q, m_d;
  logic [DBL_EXP_W-1:0]  e_q, e_d;
  logic [DBL_FRAC_W-1:0] frac_q, frac_d;
  logic [63:0]           z_q, z_d;
  logic [63:0]           out_z_q, out_z_d;

  logic [DBL_FRAC_W-1:0] rnd_frac;
  logic [DBL_EXP_W-1:0]  rnd_e;

  double_round u_round (
    .m_i    (m_q),
    .e_i    (e_q),
    .frac_o (rnd_frac),
    .e_o    (rnd_e)
  );

  always_comb begin
    state_d = state_q;
    a_ack_d = a_ack_q;
    z_stb_d = z_stb_q;
    a_d     = a_q;
    s_d     = s_q;
    m_d     = m_q;
    e_d     = e_q;
    frac_d  = frac_q;
    z_d     = z_q;
    out_z_d = out_z_q;

    unique case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a;
          a_ack_d = 1'b0;
          state_d = CONVERT_0;
        end
      end
      CONVERT_0: begin
        s_d = a_q[63];
        m_d = a_q[63] ? -a_q : a_q;
        e_d = L2D_EXP_INIT;
        // Zero bypasses normalisation, which would never terminate on it.
        if (a_q == '0) begin
          z_d     = '0;
          state_d = PUT_Z;
        end else begin
          state_d = NORMALISE;
        end
      end
      NORMALISE: begin
        if (m_q[63]) begin
          state_d = ROUND;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - DBL_EXP_ONE;
        end
      end
      ROUND: begin
        frac_d  = rnd_frac;
        e_d     = rnd_e;
        state_d = PACK;
      end
      PACK: begin
        z_d     = dbl_pack(s_q, e_q, frac_q);
        state_d = PUT_Z;
      end
      PUT_Z: begin
        z_stb_d = 1'b1;
        out_z_d = z_q;
        if (z_stb_q && output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_ack_q <= a_ack_d;
      z_stb_q <= z_stb_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q     <= a_d;
    s_q     <= s_d;
    m_q     <= m_d;
    e_q     <= e_d;
    frac_q  <= frac_d;
    z_q     <= z_d;
    out_z_q <= out_z_d;
  end

  assign input_a_ack  = a_ack_q;
  assign output_z_stb = z_stb_q;
  assign output_z     = out_z_q;

endmodule

// File: tb/tb_long_to_double.sv
// Self-checking bench for long_to_double: directed vector table, handshake and
// reset corner sequences, and randomised operands against an arithmetic model.
module tb_long_to_double;

  logic        clk;
  logic        rst;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks = 0;
  int errors = 0;

  long_to_double dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] z;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer -> binary64 via leading-one search and
  // comparison of the discarded remainder against one half ulp.
  function automatic void ref_conv(input logic [63:0] a, output logic [63:0] z, output int lat);
    logic [63:0] mag, q, rem, half;
    int p, sh;
    if (a == 64'd0) begin
      z   = 64'd0;
      lat = 2;
      return;
    end
    mag = a[63] ? (~a + 64'd1) : a;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    lat = 5 + (63 - p);
    if (p <= 52) begin
      q = mag << (52 - p);
    end else begin
      sh   = p - 52;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 53)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    z = {a[63], 11'(p + 1023), q[51:0]};
  endfunction

  task automatic send(input logic [63:0] a);
    int n = 0;
    while (!input_a_ack && n < 200) begin
      tick();
      n++;
    end
    if (!input_a_ack) chk("ack_timeout", 64'(input_a_ack), 64'd1);
    input_a     = a;
    input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    chk("ack_drop", 64'(input_a_ack), 64'd0);
  endtask

  task automatic wait_z(input logic [63:0] ez, input int el);
    int  lat = 0;
    bit  overlap = 0;
    while (!output_z_stb && lat < 100) begin
      tick();
      lat++;
      if (input_a_ack) overlap = 1;
    end
    chk("latency", 64'(lat), 64'(el));
    chk("result", output_z, ez);
    chk("ack_during_busy", 64'(overlap), 64'd0);
  endtask

  task automatic consume();
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk("stb_clear", 64'(output_z_stb), 64'd0);
  endtask

  initial begin
    logic [63:0] a, ez, hold;
    int el, dly;

    rst          = 1'b1;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;

    vecs[0] = '{64'h0000000000000000, 64'h0000000000000000, 2};
    vecs[1] = '{64'h0000000000000001, 64'h3FF0000000000000, 68};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hBFF0000000000000, 68};
    vecs[3] = '{64'h8000000000000000, 64'hC3E0000000000000, 5};
    vecs[4] = '{64'h7FFFFFFFFFFFFFFF, 64'h43E0000000000000, 6};
    vecs[5] = '{64'h0020000000000001, 64'h4340000000000000, 15};
    vecs[6] = '{64'h0020000000000003, 64'h4340000000000002, 15};
    vecs[7] = '{64'h0000000000000002, 64'h4000000000000000, 67};

    repeat (3) tick();
    chk("rst_ack", 64'(input_a_ack), 64'd0);
    chk("rst_stb", 64'(output_z_stb), 64'd0);
    rst = 1'b0;
    tick();
    chk("ack_after_rst", 64'(input_a_ack), 64'd1);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a);
      wait_z(vecs[i].z, vecs[i].lat);
      consume();
    end

    // Back-pressure: result must hold while the consumer stalls.
    send(64'h7FFFFFFFFFFFFFFF);
    wait_z(64'h43E0000000000000, 6);
    hold = output_z;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_stb", 64'(output_z_stb), 64'd1);
      chk("stall_z", output_z, hold);
      chk("stall_ack", 64'(input_a_ack), 64'd0);
    end
    consume();
    chk("ack_low_after_consume", 64'(input_a_ack), 64'd0);
    tick();
    chk("ack_high_cycle_after", 64'(input_a_ack), 64'd1);
    chk("z_held_in_get_a", output_z, hold);

    // Reset while normalising a=1: operand dropped, no transfer.
    send(64'h0000000000000001);
    repeat (20) begin
      tick();
      chk("pre_rst_no_stb", 64'(output_z_stb), 64'd0);
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_ack", 64'(input_a_ack), 64'd0);
    chk("mid_rst_stb", 64'(output_z_stb), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ack", 64'(input_a_ack), 64'd1);
    chk("post_rst_stb", 64'(output_z_stb), 64'd0);
    send(64'h0000000000000002);
    wait_z(64'h4000000000000000, 67);
    consume();

    for (int i = 0; i < 200; i++) begin
      a = {$urandom(), $urandom()};
      a = a >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = ~a + 64'd1;
      if ($urandom_range(0, 15) == 0) a = 64'd0;
      ref_conv(a, ez, el);
      send(a);
      wait_z(ez, el);
      dly = $urandom_range(0, 3);
      repeat (dly) begin
        tick();
        chk("rand_hold_stb", 64'(output_z_stb), 64'd1);
      end
      consume();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/long_to_double.md
LONG_TO_DOUBLE -- requirements
Module: long_to_double

Interface
REQ-001 SHALL have no parameters; widths are fixed at 64-bit integer and IEEE-754 binary64.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 input_a  input  64  signed two's-complement integer operand.
REQ-005 input_a_stb  input  1  producer asserts when input_a valid.
REQ-006 input_a_ack  output  1  block ready to accept operand.
REQ-007 output_z  output  64  IEEE-754 double result {sign, exp[10:0], frac[51:0]}.
REQ-008 output_z_stb  output  1  output_z valid.
REQ-009 output_z_ack  input  1  consumer accepts output_z.

Function
REQ-010 SHALL be an FSM with states get_a, convert_0, normalise, round, pack, put_z.
REQ-011 get_a: SHALL drive input_a_ack=1 (registered); operand captured on an edge where input_a_ack && input_a_stb; input_a_ack SHALL be 0 the following cycle; next state convert_0.
REQ-012 convert_0: sign s=a[63]; magnitude m=s ? -a : a as 64-bit unsigned (0x8000000000000000 yields 2^63); exponent e=1086 (63+1023).
REQ-013 convert_0: if a==0, z SHALL be 0x0000000000000000 (+0, never -0) and next state put_z; else normalise.
REQ-014 normalise: while m[63]==0, m<=m<<1, e<=e-1, one bit per cycle; when m[63]==1, next state round.
REQ-015 round: mantissa = m[63:11] (53 bits); guard=m[10], round=m[9], sticky=|m[8:0]; round-to-nearest-even: increment when guard && (round || sticky || m[11]).
REQ-016 round: on mantissa carry-out (2^53), mantissa SHALL shift right 1 and e increment by 1.
REQ-017 pack: z = {s, e[10:0], mantissa[51:0]}; next state put_z; no overflow, infinity, NaN or denormal is possible from 64-bit input.
REQ-018 put_z: output_z_stb SHALL be 1 and output_z=z held stable until an edge with output_z_stb && output_z_ack; then output_z_stb=0 next cycle and state get_a.
REQ-019 Latency: output_z_stb SHALL first be high 5+L cycles after the accept edge, L = leading-zero count of |a| (0..63); for a==0, 2 cycles; maximum 68.
REQ-020 input_a_ack and output_z_stb SHALL never be high in the same cycle; no new operand accepted before the result is consumed.
REQ-021 output_z SHALL hold the last transferred value while in get_a.

Reset
REQ-022 rst SHALL force state get_a, input_a_ack=0, output_z_stb=0, overriding any other update that cycle.
REQ-023 Reset mid-operation SHALL discard the in-flight operand with no output transfer; input_a_ack SHALL rise the first cycle after rst deasserts.
REQ-024 output_z and datapath registers need no reset value.

Structure
REQ-025 Constants bias=1023, exponent width 11, fraction width 52 SHALL live in the shared double-precision constants package used by the other FPU converters.
REQ-026 Single module; the round-to-nearest-even stage MAY be factored as sub-module double_round for reuse by the other converters.

Verification
REQ-027 a=0x0000000000000000 -> z=0x0000000000000000, stb 2 cycles after accept.
REQ-028 a=0x0000000000000001 -> z=0x3FF0000000000000, stb 68 cycles after accept; a=0xFFFFFFFFFFFFFFFF -> z=0xBFF0000000000000.
REQ-029 a=0x8000000000000000 -> z=0xC3E0000000000000; a=0x7FFFFFFFFFFFFFFF -> z=0x43E0000000000000 (round carry).
REQ-030 Tie cases: a=0x0020000000000001 -> z=0x4340000000000000 (tie to even, down); a=0x0020000000000003 -> z=0x4340000000000002 (tie to even, up).
REQ-031 Handshake: hold output_z_ack=0 for 10 cycles -> output_z_stb and output_z stable; then ack -> stb low next cycle, input_a_ack high the cycle after.
REQ-032 Assert rst during normalise of a=1 -> no output_z_stb; after release, the next operand a=2 -> z=0x4000000000000000.
